// File: rtl/biset_arbiter.sv
// biset_arbiter
//   Shares one BiSet settings bus between NUM_REQ requesters using round-robin
//   arbitration. A requester may hold the bus for a locked burst of at most
//   MAX_BURST cycles. The reply that arrives the cycle after an issue is
//   routed back to the requester that made the access.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   req_valid_i  per-requester access pending
//   req_lock_i   per-requester: keep ownership after this access
//   req_ctrl_i   per-requester ctrl, slice i = [i*CTRL_W +: CTRL_W]
//   req_data_i   per-requester write data, slice i = [i*DATA_W +: DATA_W]
//   req_ready_o  one-hot, access of requester i issued this cycle
//   rsp_valid_o  one-hot, reply for requester i present on rsp_data_o
//   rsp_data_o   shared reply data (0 when no reply is routed)
//   ctrl_o       BiSet ctrl to bus (0 when idle)
//   write_o      BiSet write data to bus (0 when idle)
//   reply_i      BiSet reply, valid the cycle after an issue
module biset_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CTRL_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REPLY_W   = 8,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_lock_i,
  input  logic [NUM_REQ*CTRL_W-1:0]   req_ctrl_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [REPLY_W-1:0]          rsp_data_o,
  output logic [CTRL_W-1:0]           ctrl_o,
  output logic [DATA_W-1:0]           write_o,
  input  logic [REPLY_W-1:0]          reply_i
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [PTR_W:0]   NREQ       = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);
  // Count value during the final cycle a locked owner may hold the bus.
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  // With a one-cycle burst limit, locking can never extend ownership.
  localparam logic             LOCK_EN    = (MAX_BURST > 1);

  typedef enum logic {
    FREE,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] issued_q;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     scan_idx;
  logic               issue;
  logic [PTR_W-1:0]   issue_idx;
  logic [NUM_REQ-1:0] ready;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + PTR_W'(1);
  endfunction

  // Round-robin search starting at ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!win_found && req_valid_i[scan_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Issue selection. Gated by rst_ni so the combinational outputs drop the
  // moment reset asserts, not at the next edge.
  always_comb begin
    issue     = 1'b0;
    issue_idx = win_idx;
    if (state_q == LOCKED) begin
      issue     = req_valid_i[owner_q];
      issue_idx = owner_q;
    end else begin
      issue = win_found;
    end
    issue = issue & rst_ni;
  end

  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ready[i] = issue && (issue_idx == PTR_W'(i));
    end
  end

  assign req_ready_o = ready;
  assign ctrl_o      = issue ? req_ctrl_i[32'(issue_idx) * CTRL_W +: CTRL_W] : '0;
  assign write_o     = issue ? req_data_i[32'(issue_idx) * DATA_W +: DATA_W] : '0;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FREE: begin
        if (issue) begin
          ptr_d = wrap_inc(win_idx);
          if (LOCK_EN && req_lock_i[win_idx]) begin
            state_d = LOCKED;
            owner_d = win_idx;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Burst limit wins over lock; the owner's access this cycle still issues.
        if ((cnt_q == BURST_LAST) || (issue && !req_lock_i[owner_q])) begin
          state_d = FREE;
          ptr_d   = wrap_inc(owner_q);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = FREE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FREE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      issued_q <= ready;
    end
  end

  assign rsp_valid_o = issued_q;
  assign rsp_data_o  = (|issued_q) ? reply_i : '0;

endmodule

// File: tb/tb_biset_arbiter.sv
module tb_biset_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int CTRL_W    = 4;
  localparam int DATA_W    = 8;
  localparam int REPLY_W   = 8;
  localparam int MAX_BURST = 8;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ-1:0]         req_lock_i;
  logic [NUM_REQ*CTRL_W-1:0]  req_ctrl_i;
  logic [NUM_REQ*DATA_W-1:0]  req_data_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ-1:0]         rsp_valid_o;
  logic [REPLY_W-1:0]         rsp_data_o;
  logic [CTRL_W-1:0]          ctrl_o;
  logic [DATA_W-1:0]          write_o;
  logic [REPLY_W-1:0]         reply_i;

  logic [CTRL_W-1:0] ctrl_tab [NUM_REQ] = '{4'h3, 4'h5, 4'h9, 4'hC};
  logic [DATA_W-1:0] data_tab [NUM_REQ] = '{8'hA5, 8'h11, 8'h22, 8'h33};

  int n_chk = 0;
  int n_err = 0;

  biset_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .REPLY_W  (REPLY_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_lock_i (req_lock_i),
    .req_ctrl_i (req_ctrl_i),
    .req_data_i (req_data_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o (rsp_data_o),
    .ctrl_o     (ctrl_o),
    .write_o    (write_o),
    .reply_i    (reply_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: rules expressed as round-robin over integers, a lock
  // deadline in absolute cycle numbers, and the last grant for the reply.
  // ---------------------------------------------------------------------
  int cyc      = 0;
  int m_ptr    = 0;
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_until  = 0;
  int m_prev   = -1;
  int n_ptr, n_owner, n_until, n_prev;
  bit n_locked;

  always @(negedge clk_i) begin : model_cmp
    int g;
    bit locked_now;
    logic [NUM_REQ-1:0] e_ready, e_rv;
    logic [CTRL_W-1:0]  e_ctrl;
    logic [DATA_W-1:0]  e_write;
    logic [REPLY_W-1:0] e_rd;
    n_ptr = m_ptr; n_locked = m_locked; n_owner = m_owner;
    n_until = m_until; n_prev = m_prev;
    g = -1;
    locked_now = m_locked && (cyc < m_until);
    if (!rst_ni) begin
      g = -1;
    end else if (locked_now) begin
      if (req_valid_i[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (g < 0 && req_valid_i[i]) g = i;
      end
    end
    e_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    e_ctrl  = (g >= 0) ? ctrl_tab[g] : '0;
    e_write = (g >= 0) ? data_tab[g] : '0;
    e_rv    = (rst_ni && m_prev >= 0) ? (4'b0001 << m_prev) : 4'b0000;
    e_rd    = (rst_ni && m_prev >= 0) ? reply_i : '0;
    check("model_ready",     32'(req_ready_o), 32'(e_ready));
    check("model_ctrl",      32'(ctrl_o),      32'(e_ctrl));
    check("model_write",     32'(write_o),     32'(e_write));
    check("model_rsp_valid", 32'(rsp_valid_o), 32'(e_rv));
    check("model_rsp_data",  32'(rsp_data_o),  32'(e_rd));
    n_prev = g;
    if (locked_now) begin
      if (g >= 0 && !req_lock_i[g]) n_locked = 1'b0;
    end else begin
      n_locked = 1'b0;
      if (g >= 0) begin
        n_ptr = (g + 1) % NUM_REQ;
        if (req_lock_i[g]) begin
          n_locked = 1'b1;
          n_owner  = g;
          n_until  = cyc + MAX_BURST;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_ptr <= 0; m_locked <= 1'b0; m_owner <= 0; m_until <= 0; m_prev <= -1;
    end else begin
      m_ptr <= n_ptr; m_locked <= n_locked; m_owner <= n_owner;
      m_until <= n_until; m_prev <= n_prev;
    end
    cyc <= cyc + 1;
  end

  // ---------------------------------------------------------------------
  // Directed stimulus with hand-computed literal expectations
  // ---------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
    reply_i = reply_i + 8'h13;
  endtask

  task automatic set_req(input logic [3:0] v, input logic [3:0] l);
    req_valid_i = v;
    req_lock_i  = l;
  endtask

  task automatic get_grant(output int g);
    @(negedge clk_i);
    g = -1;
    if (req_ready_o != '0) begin
      g = -2;
      if ($onehot(req_ready_o)) begin
        for (int i = 0; i < NUM_REQ; i++) if (req_ready_o[i]) g = i;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int g;
    int exp3 [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 0};
    rst_ni  = 1'b0;
    reply_i = 8'h40;
    set_req(4'b0000, 4'b0000);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ctrl_i[i*CTRL_W +: CTRL_W] = ctrl_tab[i];
      req_data_i[i*DATA_W +: DATA_W] = data_tab[i];
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ready",     32'(req_ready_o), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("reset_ctrl",      32'(ctrl_o),      32'h0);

    // 1: single access from requester 0
    next_cycle();
    rst_ni = 1'b1;
    set_req(4'b0001, 4'b0000);
    @(negedge clk_i);
    check("t1_ready", 32'(req_ready_o), 32'h1);
    check("t1_ctrl",  32'(ctrl_o),      32'h3);
    check("t1_write", 32'(write_o),     32'hA5);
    next_cycle();
    set_req(4'b0000, 4'b0000);
    @(negedge clk_i);
    check("t1_rsp_valid",  32'(rsp_valid_o), 32'h1);
    check("t1_rsp_data",   32'(rsp_data_o),  32'(reply_i));
    check("t1_idle_ready", 32'(req_ready_o), 32'h0);
    check("t1_idle_ctrl",  32'(ctrl_o),      32'h0);
    check("t1_idle_write", 32'(write_o),     32'h0);

    // ptr is 1; one access from requester 3 wraps it to 0
    next_cycle();
    set_req(4'b1000, 4'b0000);
    get_grant(g);
    check("wrap_grant3", 32'(g), 32'd3);

    // 2: all valid, no lock -> 0,1,2,3,0,1,2,3
    next_cycle();
    set_req(4'b1111, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      get_grant(g);
      check("t2_grant", 32'(g), 32'(k % 4));
      next_cycle();
    end

    // one access from requester 0 moves ptr to 1
    set_req(4'b0001, 4'b0000);
    get_grant(g);
    check("t3_pre_grant", 32'(g), 32'd0);

    // 3: requester 1 locks; held 8 cycles, then 2, then 0
    next_cycle();
    set_req(4'b0111, 4'b0010);
    for (int k = 0; k < 10; k++) begin
      get_grant(g);
      check("t3_grant", 32'(g), 32'(exp3[k]));
      next_cycle();
    end

    // 4: requester 2 locks then idles 3 cycles while requester 0 waits
    set_req(4'b0101, 4'b0100);
    get_grant(g);
    check("t4_lock_grant", 32'(g), 32'd2);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      set_req(4'b0001, 4'b0100);
      @(negedge clk_i);
      check("t4_idle_ready", 32'(req_ready_o), 32'h0);
      check("t4_idle_ctrl",  32'(ctrl_o),      32'h0);
    end
    next_cycle();
    set_req(4'b0101, 4'b0000);
    get_grant(g);
    check("t4_release_grant", 32'(g), 32'd2);
    next_cycle();
    set_req(4'b1001, 4'b0000);
    get_grant(g);
    check("t4_after_grant3", 32'(g), 32'd3);
    next_cycle();
    get_grant(g);
    check("t4_after_grant0", 32'(g), 32'd0);

    // 6: idle gap
    next_cycle();
    set_req(4'b0000, 4'b0000);
    repeat (3) next_cycle();

    // 5: reset asserted half a cycle after an issue
    set_req(4'b0010, 4'b0000);
    get_grant(g);
    check("t5_grant", 32'(g), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t5_rst_ready",     32'(req_ready_o), 32'h0);
    check("t5_rst_ctrl",      32'(ctrl_o),      32'h0);
    check("t5_rst_write",     32'(write_o),     32'h0);
    check("t5_rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("t5_rst_rsp_data",  32'(rsp_data_o),  32'h0);
    next_cycle();
    rst_ni = 1'b1;
    set_req(4'b0000, 4'b0000);
    @(negedge clk_i);
    check("t5_no_rsp", 32'(rsp_valid_o), 32'h0);
    next_cycle();
    set_req(4'b1111, 4'b0000);
    get_grant(g);
    check("t5_ptr0_grant", 32'(g), 32'd0);
    next_cycle();
    set_req(4'b0000, 4'b0000);
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
